// File: rtl/reg_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// reg_cmd_arbiter
//
// Round-robin arbiter that turns (address, data) register-write commands from
// several requesters into the byte stream expected by the register manager:
// one address byte, one data byte, then one idle cycle for the broadcast.
// A requester may hold req_lock to keep the grant across commands.
//
// Ports
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   req_valid  : [NREQ]   command pending per requester
//   req_addr   : [8*NREQ] byte i = register address of requester i
//   req_data   : [8*NREQ] byte i = register data of requester i
//   req_lock   : [NREQ]   requester keeps the grant after its command
//   req_ack    : [NREQ]   one-cycle pulse when requester's command is issued
//   cmd_out    : [8]      command byte (valid while cmd_wr is high)
//   cmd_wr     : command byte strobe
//   grant_id   : [IDW]    current / most recently granted requester
//   busy       : high while a command is in flight (address or data cycle)
// ---------------------------------------------------------------------------
module reg_cmd_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ <= 2) ? 1 : $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_lock,
  output logic [NREQ-1:0]   req_ack,
  output logic [7:0]        cmd_out,
  output logic              cmd_wr,
  output logic [IDW-1:0]    grant_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Requester NREQ-1 counts as "last granted" after reset so that the first
  // search starts at requester 0.
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

  state_t         state_reg, state_next;
  logic [7:0]     addr_reg,  addr_next;
  logic [7:0]     data_reg,  data_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic [IDW-1:0] last_reg,  last_next;
  logic           lock_reg,  lock_next;

  // Per-requester byte views of the flattened address/data buses.
  logic [7:0] addr_byte [NREQ];
  logic [7:0] data_byte [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
    assign addr_byte[gi] = req_addr[8*gi +: 8];
    assign data_byte[gi] = req_data[8*gi +: 8];
  end

  // -------------------------------------------------------------------------
  // Round-robin search: first valid requester after last_reg, wrapping.
  // -------------------------------------------------------------------------
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  logic [IDW-1:0] cand_idx;

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDW'((int'(last_reg) + k) % NREQ);
      if (!rr_found && req_valid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock handling. The lock persists while the owner either has a command
  // ready or still asserts req_lock; once the owner releases req_lock with
  // nothing pending, the normal round-robin search takes over in the same
  // cycle. Since last_reg equals grant_reg at that point, the search resumes
  // from grant_id+1.
  // -------------------------------------------------------------------------
  logic           hold_lock;
  logic           win_found;
  logic [IDW-1:0] win_idx;

  always_comb begin
    hold_lock = lock_reg && (req_valid[grant_reg] || req_lock[grant_reg]);
    win_found = rr_found;
    win_idx   = rr_idx;
    if (hold_lock) begin
      win_found = req_valid[grant_reg];
      win_idx   = grant_reg;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      addr_reg  <= 8'h00;
      data_reg  <= 8'h00;
      grant_reg <= '0;
      last_reg  <= LAST_INIT;
      lock_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      lock_reg  <= lock_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs. Outputs decode the state register only, so an
  // asserted reset forces them to their idle values immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    lock_next  = lock_reg;
    cmd_out    = 8'h00;
    cmd_wr     = 1'b0;
    busy       = 1'b0;
    req_ack    = '0;

    case (state_reg)
      IDLE, GAP: begin
        lock_next = hold_lock;
        if (win_found) begin
          // Command bytes are captured here; the requester may change its
          // inputs freely afterwards without corrupting the issued command.
          addr_next  = addr_byte[win_idx];
          data_next  = data_byte[win_idx];
          grant_next = win_idx;
          last_next  = win_idx;
          state_next = ADDR;
        end else begin
          state_next = IDLE;
        end
      end

      ADDR: begin
        cmd_out    = addr_reg;
        cmd_wr     = 1'b1;
        busy       = 1'b1;
        state_next = DATA;
      end

      DATA: begin
        cmd_out          = data_reg;
        cmd_wr           = 1'b1;
        busy             = 1'b1;
        req_ack[grant_reg] = 1'b1;
        lock_next        = req_lock[grant_reg];
        state_next       = GAP;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign grant_id = grant_reg;

endmodule

// File: tb/tb_reg_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_cmd_arbiter
//
// Directed bench for reg_cmd_arbiter with three requesters. Each scenario
// lists the expected cmd_wr / cmd_out / req_ack / grant_id per cycle.
// Stimulus changes and output sampling happen on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_reg_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [23:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  req_lock;
  logic [2:0]  req_ack;
  logic [7:0]  cmd_out;
  logic        cmd_wr;
  logic [1:0]  grant_id;
  logic        busy;

  int check_count = 0;
  int fail_count  = 0;
  bit auto_drop   = 1'b0;

  always #5 clk = ~clk;

  reg_cmd_arbiter #(
    .NREQ (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ack   (req_ack),
    .cmd_out   (cmd_out),
    .cmd_wr    (cmd_wr),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  // One line per completed command.
  always @(negedge clk) begin
    if (reset_n && req_ack != 3'b000)
      $display("txn req=%0d data=0x%02h ack=%b", grant_id, cmd_out, req_ack);
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and check one cycle of output.
  task automatic expect_cycle(input string tag, input logic wr,
                              input logic [7:0] out, input logic [2:0] ack,
                              input logic [1:0] gid);
    @(negedge clk);
    check_value({tag, ".wr"},   32'(cmd_wr),  32'(wr));
    check_value({tag, ".out"},  32'(cmd_out), 32'(out));
    check_value({tag, ".ack"},  32'(req_ack), 32'(ack));
    check_value({tag, ".busy"}, 32'(busy),    32'(wr));
    if (wr)
      check_value({tag, ".gid"}, 32'(grant_id), 32'(gid));
    if (auto_drop)
      req_valid = req_valid & ~req_ack;
  endtask

  // Reset, check reset outputs, then release with the given inputs applied.
  task automatic do_reset(input logic [2:0] v, input logic [2:0] l,
                          input logic [23:0] a, input logic [23:0] d);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 3'b000;
    req_lock  = 3'b000;
    #1;
    check_value("rst.wr",   32'(cmd_wr),   32'd0);
    check_value("rst.out",  32'(cmd_out),  32'd0);
    check_value("rst.busy", 32'(busy),     32'd0);
    check_value("rst.ack",  32'(req_ack),  32'd0);
    check_value("rst.gid",  32'(grant_id), 32'd0);
    @(negedge clk);
    req_valid = v;
    req_lock  = l;
    req_addr  = a;
    req_data  = d;
    reset_n   = 1'b1;
  endtask

  initial begin
    logic [1:0] g;
    int cnt0;
    int cnt1;

    reset_n   = 1'b0;
    req_valid = 3'b000;
    req_lock  = 3'b000;
    req_addr  = 24'h0;
    req_data  = 24'h0;

    // ---- Single command --------------------------------------------------
    auto_drop = 1'b1;
    do_reset(3'b001, 3'b000, 24'h000012, 24'h000034);
    expect_cycle("single_c1", 1'b1, 8'h12, 3'b000, 2'd0);
    expect_cycle("single_c2", 1'b1, 8'h34, 3'b001, 2'd0);
    expect_cycle("single_c3", 1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("single_c4", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Contention: all three valid from reset --------------------------
    do_reset(3'b111, 3'b000, 24'hA2A1A0, 24'hB2B1B0);
    expect_cycle("cont_c1",  1'b1, 8'hA0, 3'b000, 2'd0);
    expect_cycle("cont_c2",  1'b1, 8'hB0, 3'b001, 2'd0);
    expect_cycle("cont_c3",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("cont_c4",  1'b1, 8'hA1, 3'b000, 2'd1);
    expect_cycle("cont_c5",  1'b1, 8'hB1, 3'b010, 2'd1);
    expect_cycle("cont_c6",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("cont_c7",  1'b1, 8'hA2, 3'b000, 2'd2);
    expect_cycle("cont_c8",  1'b1, 8'hB2, 3'b100, 2'd2);
    expect_cycle("cont_c9",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("cont_c10", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Fairness: 0 and 1 continuously valid for 12 commands ------------
    auto_drop = 1'b0;
    do_reset(3'b011, 3'b000, 24'h005150, 24'h006160);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 12; k++) begin
      g = 2'(k % 2);
      expect_cycle("fair_addr", 1'b1, 8'(8'h50 + g), 3'b000, g);
      expect_cycle("fair_data", 1'b1, 8'(8'h60 + g), 3'(3'b001 << g), g);
      if (grant_id == 2'd0)
        cnt0++;
      else if (grant_id == 2'd1)
        cnt1++;
      if (k == 11)
        req_valid = 3'b000;
      expect_cycle("fair_gap", 1'b0, 8'h00, 3'b000, 2'd0);
    end
    check_value("fair_cnt0", 32'(cnt0), 32'd6);
    check_value("fair_cnt1", 32'(cnt1), 32'd6);
    expect_cycle("fair_idle", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Lock: requester 1 keeps the grant for 3 commands ----------------
    do_reset(3'b010, 3'b010, 24'h004140, 24'h005150);
    expect_cycle("lock_c1",  1'b1, 8'h41, 3'b000, 2'd1);
    req_valid[0] = 1'b1;
    expect_cycle("lock_c2",  1'b1, 8'h51, 3'b010, 2'd1);
    expect_cycle("lock_c3",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("lock_c4",  1'b1, 8'h41, 3'b000, 2'd1);
    expect_cycle("lock_c5",  1'b1, 8'h51, 3'b010, 2'd1);
    expect_cycle("lock_c6",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("lock_c7",  1'b1, 8'h41, 3'b000, 2'd1);
    req_lock[1] = 1'b0;
    expect_cycle("lock_c8",  1'b1, 8'h51, 3'b010, 2'd1);
    expect_cycle("lock_c9",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("lock_c10", 1'b1, 8'h40, 3'b000, 2'd0);
    expect_cycle("lock_c11", 1'b1, 8'h50, 3'b001, 2'd0);
    req_valid = 3'b000;
    expect_cycle("lock_c12", 1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("lock_c13", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Lock held with owner idle: bus stays quiet ----------------------
    auto_drop = 1'b1;
    do_reset(3'b010, 3'b010, 24'h004140, 24'h005150);
    expect_cycle("lkidle_c1", 1'b1, 8'h41, 3'b000, 2'd1);
    expect_cycle("lkidle_c2", 1'b1, 8'h51, 3'b010, 2'd1);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++)
      expect_cycle("lkidle_wait", 1'b0, 8'h00, 3'b000, 2'd0);
    req_lock[1] = 1'b0;
    expect_cycle("lkidle_c8",  1'b1, 8'h40, 3'b000, 2'd0);
    expect_cycle("lkidle_c9",  1'b1, 8'h50, 3'b001, 2'd0);
    expect_cycle("lkidle_c10", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Reset during the data cycle -------------------------------------
    do_reset(3'b010, 3'b000, 24'hBB9977, 24'hCCAA88);
    expect_cycle("rstmid_c1", 1'b1, 8'h99, 3'b000, 2'd1);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 3'b111;
    #1;
    check_value("rstmid.wr",   32'(cmd_wr),   32'd0);
    check_value("rstmid.ack",  32'(req_ack),  32'd0);
    check_value("rstmid.busy", 32'(busy),     32'd0);
    check_value("rstmid.out",  32'(cmd_out),  32'd0);
    check_value("rstmid.gid",  32'(grant_id), 32'd0);
    @(negedge clk);
    check_value("rstmid.ack2", 32'(req_ack),  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_cycle("rstmid_c2",  1'b1, 8'h77, 3'b000, 2'd0);
    expect_cycle("rstmid_c3",  1'b1, 8'h88, 3'b001, 2'd0);
    expect_cycle("rstmid_c4",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("rstmid_c5",  1'b1, 8'h99, 3'b000, 2'd1);
    expect_cycle("rstmid_c6",  1'b1, 8'hAA, 3'b010, 2'd1);
    expect_cycle("rstmid_c7",  1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("rstmid_c8",  1'b1, 8'hBB, 3'b000, 2'd2);
    expect_cycle("rstmid_c9",  1'b1, 8'hCC, 3'b100, 2'd2);
    expect_cycle("rstmid_c10", 1'b0, 8'h00, 3'b000, 2'd0);

    // ---- Withdraw: requester 2 valid for one cycle during ADDR -----------
    do_reset(3'b001, 3'b000, 24'hC20012, 24'hD20034);
    expect_cycle("wdraw_c1", 1'b1, 8'h12, 3'b000, 2'd0);
    req_valid[2] = 1'b1;
    expect_cycle("wdraw_c2", 1'b1, 8'h34, 3'b001, 2'd0);
    req_valid[2] = 1'b0;
    expect_cycle("wdraw_c3", 1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("wdraw_c4", 1'b0, 8'h00, 3'b000, 2'd0);
    expect_cycle("wdraw_c5", 1'b0, 8'h00, 3'b000, 2'd0);
    check_value("wdraw.gid", 32'(grant_id), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/reg_cmd_arbiter.md
# reg_cmd_arbiter

Arbitrates register-write commands from several on-chip and host requesters and serializes them into the two-byte address/data command stream consumed by the register manager. Each requester presents a complete (address, data) pair. The arbiter grants requesters round-robin and emits the address byte, then the data byte, on consecutive cycles, so a command is never interleaved with another. It also inserts the one idle cycle the register manager needs to broadcast each write.

## Interface

- NREQ, 2: number of requesters; legal range 2..8.
- IDW, 1 when NREQ=2, otherwise ceil(log2(NREQ)): width of grant_id.

- clk  in  1  system clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i set means requester i has a command pending.
- req_addr  in  8*NREQ  byte i is the register address for requester i.
- req_data  in  8*NREQ  byte i is the register data for requester i.
- req_lock  in  NREQ  bit i set means requester i keeps the grant after its current command.
- req_ack  out  NREQ  one-cycle pulse on bit i when requester i's command has been fully issued.
- cmd_out  out  8  command byte to the register manager.
- cmd_wr  out  1  strobe; cmd_out is valid while this is high.
- grant_id  out  IDW  index of the current or most recent granted requester.
- busy  out  1  high while a command is in flight (ADDR or DATA state).

## Operation

- States: IDLE, ADDR, DATA, GAP. Arbitration happens in IDLE and in GAP.
- Arbitration, no lock held:
  - Search req_valid starting at index (last+1) mod NREQ and wrapping; the first set bit wins.
  - last is the most recently granted index; it resets to NREQ-1, so requester 0 has first priority.
  - The winner's req_addr and req_data bytes are latched into internal registers in the arbitration cycle.
  - grant_id is set to the winner, last is updated, and the state moves to ADDR.
- Arbitration, lock held: the lock is held when req_lock[grant_id] was high in the winner's DATA cycle.
  - Only requester grant_id is considered.
  - If its req_valid is low, the arbiter stays in IDLE, still locked, until either valid rises or req_lock[grant_id] drops.
  - Once the lock drops, normal round-robin resumes from grant_id+1.
- ADDR: cmd_out is the latched address, cmd_wr=1, busy=1. Go to DATA.
- DATA: cmd_out is the latched data, cmd_wr=1, busy=1, req_ack[grant_id]=1. Sample req_lock[grant_id] into the lock flag. Go to GAP.
- GAP: cmd_wr=0, cmd_out=0, busy=0. Arbitrate.
  - Winner found: go to ADDR.
  - No winner: go to IDLE.
- IDLE: cmd_wr=0, cmd_out=0, busy=0. Arbitrate the same way as in GAP.
- Requester handshake:
  - Hold req_valid, req_addr and req_data stable until req_ack. Changing them before the grant is allowed; they are only sampled in the arbitration cycle.
  - If req_valid is still high in the cycle after req_ack, that is a new command.
- Dropping req_valid before the grant withdraws the request. Dropping it after the grant has no effect; the command completes.
- Inputs are synchronous to clk. Crossing from the fx2_clk domain is done upstream.

## Timing

- Latency: valid sampled in cycle N gives ADDR in N+1, DATA plus req_ack in N+2, and GAP in N+3.
- Maximum throughput is one command every 3 cycles (ADDR, DATA, GAP), whether from the same or different requesters.
- cmd_wr is never high for more than 2 consecutive cycles. There is always at least 1 low cycle between commands.
- Simultaneous requests: exactly one winner per arbitration cycle. The losers remain pending with no ack.
- Reset (asynchronous, in any state):
  - state=IDLE, cmd_wr=0, cmd_out=0, req_ack=0, busy=0, grant_id=0, last=NREQ-1, lock flag cleared.
  - A command interrupted mid-flight is discarded and never acked; the requester must retry.
  - Reset takes effect immediately; the outputs above are valid during reset.
- Wrap-around: after granting index NREQ-1, the search starts at index 0.

## Test plan

- Single command: requester 0 gives addr 0x12, data 0x34 → cmd_wr high 2 cycles with cmd_out 0x12 then 0x34, req_ack[0] pulses in the 0x34 cycle, next cycle is idle.
- Contention, NREQ=3: requesters 0, 1, 2 all valid from reset with addr 0xA0, 0xA1, 0xA2 → address bytes issued in order 0xA0, 0xA1, 0xA2, one command per 3 cycles, each ack exactly once.
- Fairness: requesters 0 and 1 held valid continuously for 12 commands → grants alternate 0,1,0,1,…, 6 each.
- Lock: requester 1 has lock high for 3 commands while requester 0 stays valid → requester 1 gets 3 consecutive grants; requester 0 is granted right after lock drops; while requester 1 is locked with valid low, cmd_wr stays 0.
- Reset mid-command: assert reset_n=0 during the DATA cycle → cmd_wr and req_ack drop immediately, no ack is issued, and after release requester 0 is granted first.
- Withdraw: requester 2 raises valid for 1 cycle while requester 0's command is in ADDR → requester 2 is never granted or acked.
